// File: rtl/led_pattern_controller.sv
// led_pattern_controller: debounced push-buttons set the step rate and animation mode of LEDG.
// Latency: outputs registered; a press takes effect DEBOUNCE+3 edges after KEY is first sampled low.
// Backpressure: none; free-running, each press event is consumed in the cycle it fires.

module led_pattern_controller #(
  parameter int PERIOD_MAX  = 11_000_000,
  parameter int PERIOD_MIN  = 700_000,
  parameter int PERIOD_STEP = 100_000,
  parameter int DEBOUNCE    = 500_000,
  parameter int CW          = 26
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic [7:0] LEDG,
  output logic [1:0] MODE,
  output logic       TICK
);

  localparam int DW = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [CW:0] MAX_X  = (CW+1)'(PERIOD_MAX);
  localparam logic [CW:0] MIN_X  = (CW+1)'(PERIOD_MIN);
  localparam logic [CW:0] STEP_X = (CW+1)'(PERIOD_STEP);

  typedef enum logic [1:0] {
    BOUNCE = 2'd0,
    FILL   = 2'd1,
    BLINK  = 2'd2,
    CHASE  = 2'd3
  } mode_t;

  logic          rst;
  logic [2:0]    sync_a, sync_b, stable, stable_prev, armed, press;
  logic [1:0]    warm;
  logic [DW-1:0] db_cnt [3];
  logic          slow_ev, fast_ev, mode_ev;
  logic [CW-1:0] period, period_nxt, cnt, cnt_nxt;
  logic [CW:0]   period_x, period_dn, period_up;
  logic          tick_hit;
  mode_t         mode, mode_nxt;
  logic          dir_right, dir_nxt;
  logic [7:0]    led_nxt;
  logic          tick_nxt;

  assign rst = ~KEY[0];

  // Synchronize and debounce KEY[3:1]; warm/armed suppress an event from a key already held at reset release
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync_a      <= 3'b111;
      sync_b      <= 3'b111;
      stable      <= 3'b111;
      stable_prev <= 3'b111;
      armed       <= 3'b000;
      warm        <= 2'b00;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_a      <= KEY[3:1];
      sync_b      <= sync_a;
      stable_prev <= stable;
      warm        <= {warm[0], 1'b1};
      // a key is armed once a real post-reset sample shows it released
      armed       <= armed | (sync_b & {3{warm[1]}});
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press   = stable_prev & ~stable & armed;
  assign slow_ev = press[0];
  assign fast_ev = press[1];
  assign mode_ev = press[2];

  // Saturating period update, computed one bit wider so nothing wraps
  always_comb begin
    period_x   = {1'b0, period};
    period_dn  = period_x - STEP_X;
    period_up  = period_x + STEP_X;
    period_nxt = period;
    if (fast_ev && !slow_ev) begin
      if (period_dn[CW] || (period_dn < MIN_X)) period_nxt = MIN_X[CW-1:0];
      else                                      period_nxt = period_dn[CW-1:0];
    end else if (slow_ev && !fast_ev) begin
      if (period_up > MAX_X) period_nxt = MAX_X[CW-1:0];
      else                   period_nxt = period_up[CW-1:0];
    end
  end

  // >= rather than == so a shortened period below cnt ticks immediately instead of wrapping
  assign tick_hit = ({1'b0, cnt} >= (period_x - 1'b1));

  // Mode state register
  always_ff @(posedge CLOCK_50) begin
    if (rst) mode <= BOUNCE;
    else     mode <= mode_nxt;
  end

  // Next mode: advance on a mode press, wrapping CHASE back to BOUNCE
  always_comb begin
    mode_nxt = mode;
    if (mode_ev) mode_nxt = mode_t'(mode + 2'd1);
  end

  // Pattern step, counter and tick; a mode press overrides a coincident tick
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    led_nxt  = LEDG;
    dir_nxt  = dir_right;
    tick_nxt = 1'b0;
    if (mode_ev) begin
      cnt_nxt = '0;
      dir_nxt = 1'b0;
      case (mode_nxt)
        BOUNCE:  led_nxt = 8'h01;
        FILL:    led_nxt = 8'h00;
        BLINK:   led_nxt = 8'hFF;
        default: led_nxt = 8'h11;
      endcase
    end else if (tick_hit) begin
      cnt_nxt  = '0;
      tick_nxt = 1'b1;
      case (mode)
        BOUNCE: begin
          if (!$onehot(LEDG)) begin
            led_nxt = 8'h01;
            dir_nxt = 1'b0;
          end else if (!dir_right) begin
            led_nxt = {LEDG[6:0], 1'b0};
            dir_nxt = LEDG[6];         // just moved onto bit7
          end else begin
            led_nxt = {1'b0, LEDG[7:1]};
            dir_nxt = ~LEDG[1];        // just moved onto bit0
          end
        end
        FILL:  led_nxt = (LEDG == 8'hFF) ? 8'h00 : {LEDG[6:0], 1'b1};
        BLINK: led_nxt = ~LEDG;
        default: begin
          case (LEDG)
            8'h11, 8'h22, 8'h44, 8'h88: led_nxt = {LEDG[6:0], LEDG[7]};
            default:                    led_nxt = 8'h11;
          endcase
        end
      endcase
    end
  end

  // Datapath registers: period, step counter, pattern, direction, tick pulse
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      period    <= MAX_X[CW-1:0];
      cnt       <= '0;
      LEDG      <= 8'h01;
      dir_right <= 1'b0;
      TICK      <= 1'b0;
    end else begin
      period    <= period_nxt;
      cnt       <= cnt_nxt;
      LEDG      <= led_nxt;
      dir_right <= dir_nxt;
      TICK      <= tick_nxt;
    end
  end

  assign MODE = mode;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Bench for led_pattern_controller: phase-based reference model plus directed scenarios.
// Model compared on every falling edge; directed literals pin the model's behaviour.
// Inputs driven on falling edges, away from the sampling edge.

module tb_led_pattern_controller;

  localparam int P_MAX = 20, P_MIN = 4, P_STEP = 4, DB = 3;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [7:0] ledg;
  logic [1:0] mode;
  logic       tick;

  always #5 clk = ~clk;

  led_pattern_controller #(
    .PERIOD_MAX(P_MAX), .PERIOD_MIN(P_MIN), .PERIOD_STEP(P_STEP), .DEBOUNCE(DB), .CW(8)
  ) dut (
    .CLOCK_50(clk), .KEY(key), .LEDG(ledg), .MODE(mode), .TICK(tick)
  );

  int checks = 0, errors = 0;
  int edge_no = 0, last_tick = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // ---------------- reference model: each mode is a phase index into its cycle ----------------
  bit         m_valid = 0;
  int         m_mode, m_phase, m_period, m_cnt, since_rst;
  bit         m_tick;
  bit   [2:0] m_stable, m_armed, m_ev, new_ev;
  bit   [2:0] raw [$];
  bit         hit, all_diff;

  function automatic int plen(input int md);
    case (md)
      0: return 14;
      1: return 9;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] led_of(input int md, input int ph);
    int v;
    case (md)
      0: v = (ph < 8) ? (1 << ph) : (1 << (14 - ph));
      1: v = (1 << ph) - 1;
      2: v = (ph == 0) ? 255 : 0;
      default: v = 'h11 << ph;
    endcase
    return v[7:0];
  endfunction

  always @(posedge clk) begin
    edge_no++;
    if (key[0] === 1'b0) begin
      m_valid = 1; m_mode = 0; m_phase = 0; m_period = P_MAX; m_cnt = 0; m_tick = 0;
      m_stable = 3'b111; m_armed = 0; m_ev = 0; since_rst = 0;
      raw.delete();
      for (int j = 0; j < DB + 2; j++) raw.push_back(3'b111);
    end else if (m_valid) begin
      hit = (m_cnt >= m_period - 1);
      m_tick = 0;
      if (m_ev[2]) begin
        m_mode = (m_mode + 1) % 4; m_phase = 0; m_cnt = 0;
      end else if (hit) begin
        m_phase = (m_phase + 1) % plen(m_mode); m_cnt = 0; m_tick = 1;
      end else begin
        m_cnt++;
      end
      if (m_ev[1] && !m_ev[0]) m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
      if (m_ev[0] && !m_ev[1]) m_period = (m_period + P_STEP > P_MAX) ? P_MAX : m_period + P_STEP;
      // key level is seen two edges late; stable flips after DB consecutive differing samples
      since_rst++;
      raw.push_back(key[3:1]);
      void'(raw.pop_front());
      new_ev = 0;
      for (int k = 0; k < 3; k++) begin
        if (since_rst >= 3 && raw[DB-1][k]) m_armed[k] = 1;
        all_diff = 1;
        for (int j = 0; j < DB; j++) if (raw[j][k] == m_stable[k]) all_diff = 0;
        if (all_diff) begin
          if (m_stable[k] && m_armed[k]) new_ev[k] = 1;
          m_stable[k] = ~m_stable[k];
        end
      end
      m_ev = new_ev;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_ledg", ledg, led_of(m_mode, m_phase));
      check("model_mode", mode, m_mode[1:0]);
      check("model_tick", tick, m_tick);
    end
    if (tick === 1'b1) last_tick = edge_no;
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int e);
    bit seen = 0;
    e = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin seen = 1; e = edge_no; end
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic spacing(output int s);
    int a, b;
    wait_tick(a);
    wait_tick(b);
    s = b - a;
  endtask

  task automatic press(input int k, input int hold);
    key[k] = 1'b0;
    cyc(hold);
    key[k] = 1'b1;
    cyc(DB + 6);
  endtask

  task automatic mode_press(input logic [1:0] exp_mode, input logic [7:0] exp_led, output int lat);
    int f;
    logic [1:0] old;
    bit seen = 0;
    old = mode;
    key[3] = 1'b0;
    f = edge_no + 1;
    lat = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mode !== old) begin seen = 1; lat = edge_no - f + 1; end
    end
    check("mode_step", mode, exp_mode);
    check("mode_init_led", ledg, exp_led);
    check("mode_tick_low", tick, 0);
    key[3] = 1'b1;
    cyc(DB + 6);
  endtask

  logic [7:0] exp_b  [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] exp_f  [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
  int         exp_fast [5] = '{16, 12, 8, 4, 4};
  int         exp_slow [6] = '{8, 12, 16, 20, 20, 20};

  initial begin
    int e, prev, s, t, lat;
    bit found;
    key = 4'b1110;
    cyc(3);
    check("rst_ledg", ledg, 8'h01);
    check("rst_mode", mode, 0);
    check("rst_tick", tick, 0);
    key = 4'b1111;

    // 1: bounce sequence at 20 clocks per step
    prev = -1;
    for (int i = 0; i < 15; i++) begin
      wait_tick(e);
      check("bounce_led", ledg, exp_b[i]);
      if (prev >= 0) check("bounce_spacing", e - prev, 20);
      prev = e;
    end

    // 2: speed saturation both ways
    for (int i = 0; i < 5; i++) begin
      press(2, 8); spacing(s); check("faster_period", s, exp_fast[i]);
    end
    for (int i = 0; i < 6; i++) begin
      press(1, 8); spacing(s); check("slower_period", s, exp_slow[i]);
    end

    // 3: short glitches are ignored, a long hold gives exactly one decrement
    for (int g = 0; g < 3; g++) begin
      key[2] = 1'b0; cyc(2); key[2] = 1'b1; cyc(4);
    end
    spacing(s); check("glitch_no_change", s, 20);
    key[2] = 1'b0; cyc(50); key[2] = 1'b1; cyc(10);
    spacing(s); check("hold_one_step", s, 16);

    // 4: mode cycling, press latency, FILL / BLINK / CHASE sequences
    mode_press(2'd1, 8'h00, lat);
    check("press_latency", lat, DB + 3);
    for (int i = 0; i < 9; i++) begin wait_tick(e); check("fill_led", ledg, exp_f[i]); end
    mode_press(2'd2, 8'hFF, lat);
    wait_tick(e); check("blink_led0", ledg, 8'h00);
    wait_tick(e); check("blink_led1", ledg, 8'hFF);
    mode_press(2'd3, 8'h11, lat);
    wait_tick(e); check("chase_22", ledg, 8'h22);
    wait_tick(e); check("chase_44", ledg, 8'h44);
    wait_tick(e); check("chase_88", ledg, 8'h88);
    wait_tick(e); check("chase_11", ledg, 8'h11);
    mode_press(2'd0, 8'h01, lat);

    // 5a: faster and slower in the same cycle cancel
    key[2:1] = 2'b00; cyc(8); key[2:1] = 2'b11; cyc(10);
    spacing(s); check("both_cancel", s, 16);

    // 5b: mode event landing on the tick edge
    wait_tick(t);
    cyc(10);
    key[3] = 1'b0;
    cyc(6);
    check("coinc_mode", mode, 1);
    check("coinc_led", ledg, 8'h00);
    check("coinc_tick", tick, 0);
    key[3] = 1'b1;
    wait_tick(e); check("coinc_next_tick", e - t, 32);

    // 5c: period 8 -> 4 with cnt past the new end ticks on the next edge
    press(2, 8); press(2, 8);
    spacing(s); check("period_8", s, 8);
    wait_tick(t);
    key[2] = 1'b0; cyc(8); key[2] = 1'b1;
    check("shorten_tick", last_tick - t, 7);
    cyc(DB + 6);
    spacing(s); check("period_4", s, 4);
    for (int i = 0; i < 4; i++) press(1, 8);

    // 6: reset mid-debounce in FILL at 0F, key held across reset release
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      wait_tick(e);
      if (ledg === 8'h0F) found = 1;
    end
    check("fill_0f", ledg, 8'h0F);
    key[3] = 1'b0; cyc(3);
    key[0] = 1'b0; cyc(1);
    check("midrst_mode", mode, 0);
    check("midrst_ledg", ledg, 8'h01);
    check("midrst_tick", tick, 0);
    key[0] = 1'b1;
    cyc(30);
    check("held_no_event", mode, 0);
    key[3] = 1'b1;
    spacing(s); check("midrst_period", s, 20);
    mode_press(2'd1, 8'h00, lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
